// File: rtl/hex_sparse_frame_writer_if.sv
// Bus bundle for the sparse hex frame writer: rasteriser-side beat handshake,
// frame-buffer write port and per-frame status.
interface hex_sparse_frame_writer_if #(
  parameter int LANES = 10,
  parameter int DEPTH = 256,
  parameter int QW    = 16,
  parameter int RW    = 16,
  parameter int DW    = 8,
  parameter int MW    = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) ();

  logic                  frame_start;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_mask;
  logic [LANES*QW-1:0]   in_q;
  logic [LANES*RW-1:0]   in_r;
  logic [LANES*DW-1:0]   in_depth;
  logic [LANES*MW-1:0]   in_material;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [AW:0]           slot_count;
  logic [31:0]           write_count;
  logic [31:0]           skip_count;
  logic                  overflow;
  logic                  busy;

  // Producer side: rasteriser / testbench
  modport master (
    output frame_start, in_valid, in_mask, in_q, in_r, in_depth, in_material,
    input  in_ready, mem_we, mem_addr, mem_wdata, slot_count, write_count,
           skip_count, overflow, busy
  );

  // Writer side
  modport slave (
    input  frame_start, in_valid, in_mask, in_q, in_r, in_depth, in_material,
    output in_ready, mem_we, mem_addr, mem_wdata, slot_count, write_count,
           skip_count, overflow, busy
  );

endinterface

// File: rtl/hex_sparse_frame_writer.sv
// Sparse hex frame writer: latches a beat of LANES hex events, walks the lanes
// one per cycle and writes each valid event into the next frame-buffer slot,
// suppressing the write when the slot already holds the same word from the
// previous frame (tracked in a local shadow copy).
module hex_sparse_frame_writer #(
  parameter int LANES = 10,
  parameter int DEPTH = 256,
  parameter int QW    = 16,
  parameter int RW    = 16,
  parameter int DW    = 8,
  parameter int MW    = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_sparse_frame_writer_if.slave bus
);

  localparam int              DATA_W    = QW + RW + DW + MW;
  localparam int              LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
  localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state;
  logic [LW-1:0]        lane;
  logic [LANES-1:0]     beat_mask;
  logic [LANES*QW-1:0]  beat_q;
  logic [LANES*RW-1:0]  beat_r;
  logic [LANES*DW-1:0]  beat_depth;
  logic [LANES*MW-1:0]  beat_material;
  logic                 pending_fs;
  logic [DEPTH-1:0]     shadow_vld;
  logic [WIDTH-1:0]     shadow [DEPTH];

  logic                 lane_valid;
  logic [WIDTH-1:0]     lane_data;
  logic [AW-1:0]        slot_addr;
  logic                 slot_full;
  logic                 slot_hit;
  logic                 do_write;
  logic                 do_skip;
  logic                 do_drop;

  // Slot word layout: event fields in the top bits, zero padding below.
  function automatic logic [WIDTH-1:0] pack_slot(
    input logic [QW-1:0] q,
    input logic [RW-1:0] r,
    input logic [DW-1:0] d,
    input logic [MW-1:0] m
  );
    logic [WIDTH-1:0] word;
    word = '0;
    word[WIDTH-1 -: DATA_W] = {q, r, d, m};
    return word;
  endfunction

  // Decode the lane under scan and decide write / skip / drop for it.
  always_comb begin
    lane_valid = beat_mask[lane];
    lane_data  = pack_slot(beat_q[lane*QW +: QW], beat_r[lane*RW +: RW],
                           beat_depth[lane*DW +: DW], beat_material[lane*MW +: MW]);
    slot_addr  = bus.slot_count[AW-1:0];
    slot_full  = (bus.slot_count == FULL);
    slot_hit   = shadow_vld[slot_addr] && (shadow[slot_addr] == lane_data);
    if ((state == SCAN) && lane_valid) begin
      do_drop  = slot_full;
      do_skip  = !slot_full && slot_hit;
      do_write = !slot_full && !slot_hit;
    end else begin
      do_drop  = 1'b0;
      do_skip  = 1'b0;
      do_write = 1'b0;
    end
  end

  // Shadow copy of the words last written to each slot (validity kept separately).
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      shadow[slot_addr] <= lane_data;
    end
  end

  // Control FSM, counters and registered frame-buffer port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lane            <= '0;
      beat_mask       <= '0;
      beat_q          <= '0;
      beat_r          <= '0;
      beat_depth      <= '0;
      beat_material   <= '0;
      pending_fs      <= 1'b0;
      shadow_vld      <= '0;
      bus.in_ready    <= 1'b1;
      bus.busy        <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.slot_count  <= '0;
      bus.write_count <= 32'd0;
      bus.skip_count  <= 32'd0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          pending_fs <= 1'b0;
          // A new frame clears the per-frame status before any lane of a
          // beat accepted in the same cycle is placed.
          if (bus.frame_start) begin
            bus.slot_count  <= '0;
            bus.write_count <= 32'd0;
            bus.skip_count  <= 32'd0;
            bus.overflow    <= 1'b0;
          end
          if (bus.in_valid) begin
            beat_mask     <= bus.in_mask;
            beat_q        <= bus.in_q;
            beat_r        <= bus.in_r;
            beat_depth    <= bus.in_depth;
            beat_material <= bus.in_material;
            lane          <= '0;
            state         <= SCAN;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (do_drop) begin
            bus.overflow <= 1'b1;
          end
          if (do_skip) begin
            bus.slot_count <= bus.slot_count + (AW+1)'(1);
            bus.skip_count <= bus.skip_count + 32'd1;
          end
          if (do_write) begin
            bus.mem_we            <= 1'b1;
            bus.mem_addr          <= slot_addr;
            bus.mem_wdata         <= lane_data;
            shadow_vld[slot_addr] <= 1'b1;
            bus.slot_count        <= bus.slot_count + (AW+1)'(1);
            bus.write_count       <= bus.write_count + 32'd1;
          end
          if (lane == LAST_LANE) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            pending_fs   <= 1'b0;
            // The beat finishes in the old frame; a frame_start seen during
            // the scan takes effect only now, overriding the last lane's counts.
            if (pending_fs || bus.frame_start) begin
              bus.slot_count  <= '0;
              bus.write_count <= 32'd0;
              bus.skip_count  <= 32'd0;
              bus.overflow    <= 1'b0;
            end
          end else begin
            lane <= lane + LW'(1);
            if (bus.frame_start) begin
              pending_fs <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_sparse_frame_writer.sv
// Bench for the sparse hex frame writer: directed scenarios followed by random
// beats, all checked cycle by cycle against a slot-level reference model.
module tb_hex_sparse_frame_writer;

  localparam int LANES = 10;
  localparam int DEPTH = 16;
  localparam int QW    = 16;
  localparam int RW    = 16;
  localparam int DW    = 8;
  localparam int MW    = 8;
  localparam int WIDTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int PAD   = WIDTH - (QW + RW + DW + MW);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  hex_sparse_frame_writer_if #(
    .LANES(LANES), .DEPTH(DEPTH), .QW(QW), .RW(RW), .DW(DW), .MW(MW),
    .WIDTH(WIDTH), .AW(AW)
  ) bus ();

  hex_sparse_frame_writer #(
    .LANES(LANES), .DEPTH(DEPTH), .QW(QW), .RW(RW), .DW(DW), .MW(MW),
    .WIDTH(WIDTH), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [WIDTH-1:0] m_sh  [DEPTH];
  bit               m_vld [DEPTH];
  int               m_slot;
  int unsigned      m_wr;
  int unsigned      m_sk;
  bit               m_ovf;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_data;

  // beat under construction
  logic [QW-1:0]    bq [LANES];
  logic [RW-1:0]    br [LANES];
  logic [DW-1:0]    bd [LANES];
  logic [MW-1:0]    bm [LANES];
  logic [LANES-1:0] bmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slot_word(input int k);
    logic [WIDTH-1:0] w;
    w = WIDTH'({bq[k], br[k], bd[k], bm[k]});
    return w << PAD;
  endfunction

  task automatic model_clear();
    m_slot = 0;
    m_wr   = 0;
    m_sk   = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Place lane k of the beat into the frame; reports whether a write is due.
  task automatic model_lane(input int k, output bit we);
    logic [WIDTH-1:0] w;
    we = 1'b0;
    w  = slot_word(k);
    if (bmask[k]) begin
      if (m_slot == DEPTH) begin
        m_ovf = 1'b1;
      end else if (m_vld[m_slot] && m_sh[m_slot] == w) begin
        m_slot++;
        m_sk++;
      end else begin
        we            = 1'b1;
        m_addr        = AW'(m_slot);
        m_data        = w;
        m_sh[m_slot]  = w;
        m_vld[m_slot] = 1'b1;
        m_slot++;
        m_wr++;
      end
    end
  endtask

  task automatic check_all(input string tag, input bit we, input bit bsy);
    chk({tag, ".mem_we"},      64'(bus.mem_we),      64'(we));
    chk({tag, ".mem_addr"},    64'(bus.mem_addr),    64'(m_addr));
    chk({tag, ".mem_wdata"},   64'(bus.mem_wdata),   64'(m_data));
    chk({tag, ".slot_count"},  64'(bus.slot_count),  64'(m_slot));
    chk({tag, ".write_count"}, 64'(bus.write_count), 64'(m_wr));
    chk({tag, ".skip_count"},  64'(bus.skip_count),  64'(m_sk));
    chk({tag, ".overflow"},    64'(bus.overflow),    64'(m_ovf));
    chk({tag, ".busy"},        64'(bus.busy),        64'(bsy));
    chk({tag, ".in_ready"},    64'(bus.in_ready),    64'(!bsy));
  endtask

  task automatic drive_beat();
    bus.in_mask = bmask;
    for (int k = 0; k < LANES; k++) begin
      bus.in_q[k*QW +: QW]        = bq[k];
      bus.in_r[k*RW +: RW]        = br[k];
      bus.in_depth[k*DW +: DW]    = bd[k];
      bus.in_material[k*MW +: MW] = bm[k];
    end
  endtask

  task automatic garbage_inputs();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_mask  = LANES'($urandom);
    for (int k = 0; k < LANES; k++) begin
      bus.in_q[k*QW +: QW]        = QW'($urandom);
      bus.in_r[k*RW +: RW]        = RW'($urandom);
      bus.in_depth[k*DW +: DW]    = DW'($urandom);
      bus.in_material[k*MW +: MW] = MW'($urandom);
    end
  endtask

  // Entered and left #1 after a rising edge with the writer idle.
  task automatic run_beat(input bit fs_now, input int fs_at, input int rst_at, input bit garbage);
    bit we;
    bit pend;
    bit aborted;
    pend    = 1'b0;
    aborted = 1'b0;
    drive_beat();
    bus.in_valid    = 1'b1;
    bus.frame_start = fs_now;
    @(posedge clk); #1;
    if (fs_now) model_clear();
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    for (int k = 0; k < LANES && !aborted; k++) begin
      if (garbage) garbage_inputs();
      if (k == rst_at) begin
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("rst_mid_scan", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          @(negedge clk);
          check_all("after_rst", 1'b0, 1'b0);
        end
        aborted = 1'b1;
      end else begin
        if (k == fs_at) begin
          bus.frame_start = 1'b1;
          pend = 1'b1;
        end
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        model_lane(k, we);
        if (k == LANES - 1) begin
          bus.in_valid = 1'b0;
          if (pend) model_clear();
        end
        @(negedge clk);
        check_all("scan", we, k != LANES - 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all("idle", 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    model_clear();
    @(negedge clk);
    check_all("frame_start", 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic ramp_beat(input int base);
    for (int k = 0; k < LANES; k++) begin
      bq[k] = QW'(base + k);
      br[k] = RW'(2 * k);
      bd[k] = DW'(k);
      bm[k] = 8'h01;
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_mask     = '0;
    bus.in_q        = '0;
    bus.in_r        = '0;
    bus.in_depth    = '0;
    bus.in_material = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0);
    @(posedge clk); #1;

    // full beat into a fresh frame: ten writes to slots 0..9
    ramp_beat(0);
    bmask = 10'h3FF;
    run_beat(1'b1, -1, -1, 1'b0);
    chk("t1.slot_count",  64'(bus.slot_count),  64'd10);
    chk("t1.write_count", 64'(bus.write_count), 64'd10);
    chk("t1.skip_count",  64'(bus.skip_count),  64'd0);

    // identical beat in the next frame: all suppressed
    run_beat(1'b1, -1, -1, 1'b0);
    chk("t2.write_count", 64'(bus.write_count), 64'd0);
    chk("t2.skip_count",  64'(bus.skip_count),  64'd10);

    // one changed material: exactly one write
    bm[4] = 8'h02;
    run_beat(1'b1, -1, -1, 1'b0);
    chk("t3.write_count", 64'(bus.write_count), 64'd1);
    chk("t3.mem_addr",    64'(bus.mem_addr),    64'd4);

    // sparse mask 0x205: lanes 0,2,9 packed into slots 0,1,2
    ramp_beat(100);
    bmask = 10'h205;
    run_beat(1'b1, -1, -1, 1'b0);
    chk("t4.write_count", 64'(bus.write_count), 64'd3);
    chk("t4.mem_addr",    64'(bus.mem_addr),    64'd2);

    // two full beats overrun the 16 slots
    ramp_beat(200);
    bmask = 10'h3FF;
    run_beat(1'b1, -1, -1, 1'b0);
    ramp_beat(300);
    run_beat(1'b0, -1, -1, 1'b0);
    chk("t5.overflow",   64'(bus.overflow),   64'd1);
    chk("t5.slot_count", 64'(bus.slot_count), 64'd16);
    pulse_fs();
    chk("t5.overflow_cleared", 64'(bus.overflow), 64'd0);

    // frame_start mid scan, then a beat that starts at slot 0
    ramp_beat(400);
    run_beat(1'b1, -1, -1, 1'b0);
    ramp_beat(500);
    run_beat(1'b0, 4, -1, 1'b1);
    chk("t6.slot_after_pending_fs", 64'(bus.slot_count), 64'd0);
    ramp_beat(600);
    run_beat(1'b0, -1, -1, 1'b0);
    chk("t6.slot_count", 64'(bus.slot_count), 64'd10);
    // reset mid scan, then the same beat must be rewritten in full
    run_beat(1'b1, -1, 2, 1'b0);
    run_beat(1'b1, -1, -1, 1'b0);
    chk("t6.rewrite_all", 64'(bus.write_count), 64'd10);

    // random beats with small data ranges so repeats and skips are common
    for (int n = 0; n < 60; n++) begin
      bit fs_now;
      int fs_at;
      int rst_at;
      for (int k = 0; k < LANES; k++) begin
        bq[k] = QW'($urandom_range(0, 1));
        br[k] = RW'($urandom_range(0, 1));
        bd[k] = DW'($urandom_range(0, 1));
        bm[k] = MW'($urandom_range(0, 1));
      end
      bmask  = LANES'($urandom);
      fs_now = ($urandom_range(0, 3) == 0);
      fs_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LANES - 2)) : -1;
      rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, LANES - 1)) : -1;
      run_beat(fs_now, fs_at, rst_at, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
